// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam int   UART_DATA_BITS   = 8;

  localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Core-side request/status bundle for the UART transmitter.
// master = control decoder, slave = uart_tx_engine.
interface uart_tx_engine_if;

  logic       send;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output send,
    output data,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  send,
    input  data,
    output busy,
    output done,
    output overrun
  );

endinterface

// File: rtl/uart_tx_engine_baud_tick.sv
// Bit-period divider: bit_end pulses on the last cycle of each bit.
import uart_pkg::*;

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  // Wrap exactly at the boundary so no drift accumulates.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter; serialises bus.data on a send strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
import uart_pkg::*;

module uart_tx_engine #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_engine_if.slave   bus,
  output logic              tx
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = ST_PARITY;
`endif
  localparam logic [2:0] STOP   = ST_STOP;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [2:0] state;
  logic [7:0] shift;
  logic [2:0] idx;
  logic       done_q;
  logic       busy;
  logic       accept;
  logic       bit_end;

  assign busy   = (state != IDLE);
  assign accept = bus.send && !busy;

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.overrun = bus.send && busy;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (busy),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shift  <= '0;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.send) begin
            state <= START;
            shift <= bus.data;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            idx   <= idx + 3'd1;
            if (idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx = UART_IDLE_LEVEL;
    unique case (state)
      START:   tx = UART_START_LEVEL;
      DATA:    tx = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = par_q;
`endif
      STOP:    tx = UART_STOP_LEVEL;
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  a_done_idle: assert property (
    @(posedge clk) disable iff (reset) done_q |-> !busy
  );

endmodule
